// File: rtl/qtcore_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : qtcore_seq_ctrl
// Brief   : Command sequencer for a scan-loaded core. It handles LOAD (byte-wise
//           chain swap), RUN (run until halt) and STEP (one cycle).
//           Optional watchdog on RUN: define QTCORE_SEQ_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module qtcore_seq_ctrl #(
  parameter int CHAIN_LEN = 160,
  parameter int RUN_MAX   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] din_data,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout_data,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       proc_en,
  input  logic       halt,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int          NBYTES    = CHAIN_LEN / 8;
  localparam logic [15:0] LAST_BYTE = 16'(NBYTES - 1);
  localparam logic [1:0]  OP_LOAD   = 2'b01;
  localparam logic [1:0]  OP_RUN    = 2'b10;
  localparam logic [1:0]  OP_STEP   = 2'b11;
  // An illegal configuration never offers cmd_ready, so it stays inert.
  localparam logic PARAM_OK = (CHAIN_LEN >= 8) && (CHAIN_LEN % 8 == 0) &&
                              (RUN_MAX >= 1) && (RUN_MAX <= 65535);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_WAIT  = 3'd1,
    S_LD_SHIFT = 3'd2,
    S_LD_OUT   = 3'd3,
    S_RUN      = 3'd4,
    S_STEP     = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t      state_q;
  logic        live_q;
  logic [15:0] byte_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
`ifdef QTCORE_SEQ_WATCHDOG_EN
  localparam logic [15:0] LAST_CYC = 16'(RUN_MAX - 1);
  logic [15:0] cyc_q;
  logic        timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      live_q     <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
`ifdef QTCORE_SEQ_WATCHDOG_EN
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      live_q <= PARAM_OK;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (cmd_op)
              OP_LOAD: begin
                byte_cnt_q <= '0;
                state_q    <= S_LD_WAIT;
              end
              OP_RUN: begin
`ifdef QTCORE_SEQ_WATCHDOG_EN
                cyc_q <= '0;
`endif
                state_q <= halt ? S_FIN : S_RUN;
              end
              OP_STEP: state_q <= S_STEP;
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_LD_WAIT: begin
          if (din_valid) begin
            shreg_q   <= din_data;
            bit_cnt_q <= '0;
            state_q   <= S_LD_SHIFT;
          end
        end
        S_LD_SHIFT: begin
          // Chain bits leaving the core enter at the top, so after 8 shifts
          // the register holds the displaced byte LSB-aligned.
          shreg_q   <= {scan_out, shreg_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= S_LD_OUT;
        end
        S_LD_OUT: begin
          if (dout_ready) begin
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              state_q    <= S_FIN;
            end else begin
              byte_cnt_q <= byte_cnt_q + 16'd1;
              state_q    <= S_LD_WAIT;
            end
          end
        end
        S_RUN: begin
          if (halt) state_q <= S_FIN;
`ifdef QTCORE_SEQ_WATCHDOG_EN
          else if (cyc_q == LAST_CYC) begin
            timeout_q <= 1'b1;
            state_q   <= S_FIN;
          end else cyc_q <= cyc_q + 16'd1;
`endif
        end
        S_STEP: state_q <= S_FIN;
        S_FIN: begin
`ifdef QTCORE_SEQ_WATCHDOG_EN
          timeout_q <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = live_q && (state_q == S_IDLE);
  assign din_ready   = (state_q == S_LD_WAIT);
  assign dout_valid  = (state_q == S_LD_OUT);
  assign dout_data   = dout_valid ? shreg_q : 8'h00;
  assign scan_enable = (state_q == S_LD_SHIFT);
  assign scan_in     = scan_enable && shreg_q[0];
  assign proc_en     = (state_q == S_RUN) || (state_q == S_STEP);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
`ifdef QTCORE_SEQ_WATCHDOG_EN
  assign timeout     = (state_q == S_FIN) && timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/qtcore_seq_ctrl.md
QTCORE_SEQ_CTRL -- requirements
Module: qtcore_seq_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 160, scan chain length in bits; must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter RUN_MAX, default 4096, RUN cycle budget; valid range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit, command offer.
REQ-006 SHALL have port cmd_ready, output, 1 bit, command accept.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 NOP, 01 LOAD, 10 RUN, 11 STEP.
REQ-008 SHALL have ports din_valid (input, 1), din_ready (output, 1) and din_data (input, 8): byte stream into the chain.
REQ-009 SHALL have ports dout_valid (output, 1), dout_ready (input, 1) and dout_data (output, 8): byte stream out of the chain.
REQ-010 SHALL have ports scan_enable (output, 1), scan_in (output, 1) and scan_out (input, 1): core scan chain.
REQ-011 SHALL have ports proc_en (output, 1) and halt (input, 1): core execution control.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and timeout (output, 1, one-cycle pulse).

Function
REQ-013 SHALL implement the FSM states IDLE, LD_WAIT, LD_SHIFT, LD_OUT, RUN, STEP and FIN.
REQ-014 SHALL assert cmd_ready only in IDLE; a handshake is cmd_valid&cmd_ready on a clock edge.
REQ-015 NOP SHALL be accepted with no state change and no done pulse.
REQ-016 LOAD SHALL transfer CHAIN_LEN/8 bytes in order: IDLE->LD_WAIT->LD_SHIFT->LD_OUT, back to LD_WAIT per byte, then FIN after the last dout handshake.
REQ-017 LD_WAIT SHALL assert din_ready; each din handshake SHALL latch din_data into the shift register and enter LD_SHIFT.
REQ-018 LD_SHIFT SHALL last exactly 8 cycles with scan_enable=1, drive scan_in = shift-register bit 0 (LSB first), and shift scan_out in at bit 7 each cycle.
REQ-019 LD_OUT SHALL hold dout_valid=1 and dout_data = the captured byte, stable until dout_ready; no new din is consumed meanwhile.
REQ-020 Byte k of dout SHALL be the chain bits displaced by the shifts of byte k: old chain contents out, LSB first.
REQ-021 RUN SHALL hold proc_en=1 from the cycle after acceptance until halt is sampled 1; proc_en SHALL be 0 in the cycle after that sample, then FIN.
REQ-022 If halt=1 on the RUN acceptance edge, the block SHALL go straight to FIN without asserting proc_en.
REQ-023 STEP SHALL assert proc_en for exactly one cycle, regardless of halt, then FIN.
REQ-024 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-025 scan_enable and proc_en SHALL never be 1 in the same cycle.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 din_ready, dout_valid, scan_enable and proc_en SHALL be 0 in every state not named for them above.
REQ-028 An unused cmd_valid while busy SHALL be ignored and not queued.

Reset
REQ-029 On any edge with rst_n=0, the block SHALL enter IDLE.
REQ-030 Reset SHALL zero the byte counter, bit counter, cycle counter and shift register.
REQ-031 While rst_n=0, every output SHALL be 0 except cmd_ready, which is 1 from the first edge after release.
REQ-032 Reset mid-LOAD or mid-RUN SHALL abort the operation immediately; partially shifted chain contents are not restored and no done is produced.

Configuration
REQ-033 With QTCORE_SEQ_WATCHDOG_EN defined, RUN SHALL count proc_en cycles; on reaching RUN_MAX without halt, proc_en SHALL drop next cycle and FIN SHALL pulse done and timeout together.
REQ-034 Without QTCORE_SEQ_WATCHDOG_EN, RUN SHALL wait indefinitely for halt, timeout SHALL be tied 0, and no cycle counter is built.

Verification
REQ-035 CHAIN_LEN=16, LOAD, din 0xA5 then 0x3C, chain preloaded 0x1234 -> scan_in serial 1,0,1,0,0,1,0,1 then 0x3C LSB-first; dout 0x34 then 0x12; done 1 cycle after second dout handshake.
REQ-036 LOAD with dout_ready held 0 for 5 cycles after the first byte -> dout_data stable, din_ready 0, scan_enable 0 throughout the stall.
REQ-037 RUN, halt rises 10 cycles after acceptance -> proc_en high exactly 10 cycles, then done pulse, cmd_ready 1 next cycle.
REQ-038 RUN with halt=1 at acceptance -> proc_en never 1; done the next cycle. STEP -> proc_en high exactly 1 cycle, then done.
REQ-039 With QTCORE_SEQ_WATCHDOG_EN and RUN_MAX=8, halt held 0 -> proc_en high 8 cycles, then done=timeout=1 in the same cycle.
REQ-040 rst_n=0 during the 4th LD_SHIFT cycle -> next edge: scan_enable=0, busy=0, no done; LOAD after release restarts at byte 0.
